convert_user_ctrl: RTL

CONVERT_USER_CTRL -- requirements
Module: convert_user_ctrl

---
 rtl/convert_user_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/convert_user_ctrl.sv
// -----------------------------------------------------------------------------
// convert_user_ctrl
//
// Purpose:
//   Converts a raw user code into a registered user index. A code is accepted
//   with a valid/ready handshake, checked against the enrolled user range, and
//   reported as a one-cycle CONV_VALID (good code) or CONV_ERR (rejected code)
//   pulse. With the optional lockout feature, too many consecutive rejected
//   codes put the block into a timed lockout during which no codes are taken.
//
// Configuration macro:
//   CONVERT_USER_LOCKOUT_EN - when defined, enables the fail counter, the lock
//                             counter and the LOCK state. When undefined,
//                             MAX_FAIL and LOCK_CYC are accepted but unused
//                             and LOCKED is tied low.
//
// Parameters:
//   USER_W    - width of the raw user code CK_U
//   IDX_W     - width of the converted index CONV_U (NUM_USERS <= 2**IDX_W-1)
//   NUM_USERS - number of enrolled users (indices 1..NUM_USERS, 0 = no user)
//   MAX_FAIL  - consecutive rejected codes that trigger lockout (1..15)
//   LOCK_CYC  - lockout duration in clock cycles (1..65535)
//
// Ports:
//   CLK        in   single clock, rising edge
//   RST_N      in   synchronous reset, active-low
//   CK_U       in   raw user code
//   CK_VALID   in   CK_U is valid this cycle
//   CK_READY   out  block accepts a code this cycle (IDLE only)
//   CONV_U     out  registered converted user index
//   CONV_VALID out  one-cycle pulse: CONV_U holds a valid user
//   CONV_ERR   out  one-cycle pulse: last code rejected
//   LOCKED     out  high while in lockout
// -----------------------------------------------------------------------------
module convert_user_ctrl #(
  parameter int USER_W    = 3,
  parameter int IDX_W     = 2,
  parameter int NUM_USERS = 3,
  parameter int MAX_FAIL  = 3,
  parameter int LOCK_CYC  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [USER_W-1:0] CK_U,
  input  logic              CK_VALID,
  output logic              CK_READY,
  output logic [IDX_W-1:0]  CONV_U,
  output logic              CONV_VALID,
  output logic              CONV_ERR,
  output logic              LOCKED
);

`ifdef CONVERT_USER_LOCKOUT_EN
  typedef enum logic [1:0] {IDLE, CHECK, OUT, LOCK} state_e;
`else
  typedef enum logic [1:0] {IDLE, CHECK, OUT} state_e;
`endif

  state_e state_q, state_d;

  logic [USER_W-1:0] code_q, code_d;
  logic [IDX_W-1:0]  convU_q, convU_d;
  logic              convValid_q, convValid_d;
  logic              convErr_q, convErr_d;

`ifdef CONVERT_USER_LOCKOUT_EN
  logic [3:0]  failCnt_q, failCnt_d;
  logic [15:0] lockCnt_q, lockCnt_d;
`endif

  // The candidate index is built one bit wider than the code so that the
  // "+1" can never wrap. The range check is done on this wide value and the
  // truncation to IDX_W happens only afterwards, so an index that does not
  // fit in CONV_U is reported as invalid instead of aliasing onto a user.
  logic [USER_W:0]  idxWide;
  logic             codeOk;
  logic [IDX_W-1:0] idxConv;

  always_comb begin
    idxWide = {1'b0, (code_q >> 1)} + (USER_W + 1)'(1);
    codeOk  = code_q[0] && (32'(idxWide) <= 32'(NUM_USERS));
    idxConv = IDX_W'(idxWide);
  end

  // Next-state and datapath logic. The result registers are loaded in CHECK
  // so the pulse is visible for exactly the OUT cycle; the default of zero
  // for the pulse flags drops them again on the edge that leaves OUT.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    convU_d     = convU_q;
    convValid_d = 1'b0;
    convErr_d   = 1'b0;
`ifdef CONVERT_USER_LOCKOUT_EN
    failCnt_d   = failCnt_q;
    lockCnt_d   = lockCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (CK_VALID) begin
          code_d  = CK_U;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (codeOk) begin
          convU_d     = idxConv;
          convValid_d = 1'b1;
`ifdef CONVERT_USER_LOCKOUT_EN
          failCnt_d   = '0;
`endif
        end else begin
          convU_d   = '0;
          convErr_d = 1'b1;
`ifdef CONVERT_USER_LOCKOUT_EN
          if (failCnt_q != 4'hF) begin
            failCnt_d = failCnt_q + 4'd1;
          end
`endif
        end
        state_d = OUT;
      end
      OUT: begin
`ifdef CONVERT_USER_LOCKOUT_EN
        // The fail counter already includes the code just reported.
        if (failCnt_q == 4'(MAX_FAIL)) begin
          state_d   = LOCK;
          lockCnt_d = '0;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
`ifdef CONVERT_USER_LOCKOUT_EN
      LOCK: begin
        // Counting from 0 to LOCK_CYC-1 keeps LOCK for exactly LOCK_CYC cycles.
        if (lockCnt_q == 16'(LOCK_CYC - 1)) begin
          state_d   = IDLE;
          failCnt_d = '0;
          lockCnt_d = '0;
        end else begin
          lockCnt_d = lockCnt_q + 16'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      code_q      <= '0;
      convU_q     <= '0;
      convValid_q <= 1'b0;
      convErr_q   <= 1'b0;
`ifdef CONVERT_USER_LOCKOUT_EN
      failCnt_q   <= '0;
      lockCnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      convU_q     <= convU_d;
      convValid_q <= convValid_d;
      convErr_q   <= convErr_d;
`ifdef CONVERT_USER_LOCKOUT_EN
      failCnt_q   <= failCnt_d;
      lockCnt_q   <= lockCnt_d;
`endif
    end
  end

  assign CK_READY   = (state_q == IDLE);
  assign CONV_U     = convU_q;
  assign CONV_VALID = convValid_q;
  assign CONV_ERR   = convErr_q;

`ifdef CONVERT_USER_LOCKOUT_EN
  assign LOCKED = (state_q == LOCK);
`else
  assign LOCKED = 1'b0;

  // MAX_FAIL and LOCK_CYC stay on the interface so both builds can be
  // instantiated identically; nothing in this build depends on them.
  if (MAX_FAIL > 0 && LOCK_CYC > 0) begin : gLockParamsUnused
  end
`endif

endmodule
